// File: rtl/dma_bus_arbiter.sv
// dma_bus_arbiter: shares the external bus between the 8227 core and a memory-to-memory DMA engine
module dma_bus_arbiter #(
  parameter int LEN_W = 8,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             mem_ready,
  input  logic [7:0]       cpu_addr_hi,
  input  logic [7:0]       cpu_addr_lo,
  input  logic [7:0]       cpu_data_out,
  input  logic             cpu_rnw,
  output logic             cpu_ready,
  output logic [7:0]       ext_addr_hi,
  output logic [7:0]       ext_addr_lo,
  output logic [7:0]       ext_data_out,
  output logic             ext_rnw,
  input  logic [7:0]       ext_data_in,
  input  logic             dma_start,
  input  logic [15:0]      dma_src,
  input  logic [15:0]      dma_dst,
  input  logic [LEN_W-1:0] dma_len,
  output logic             dma_busy,
  output logic             dma_done
);
  localparam int GW = $clog2(GAP_CYCLES + 2);
  typedef enum logic [2:0] {IDLE, REQ, RD, WR, GAP} state_t;
  state_t state;
  logic hold;
  logic [15:0] cur_src, cur_dst, dma_addr;
  logic [LEN_W:0] remaining;
  logic [GW-1:0] gap_cnt;
  logic [7:0] data_buf;
  logic dma_own;
  always_comb begin
    dma_own = state == RD || state == WR;
    dma_addr = state == RD ? cur_src : cur_dst;
    cpu_ready = mem_ready & ~hold;
    ext_addr_hi = dma_own ? dma_addr[15:8] : cpu_addr_hi;
    ext_addr_lo = dma_own ? dma_addr[7:0] : cpu_addr_lo;
    ext_data_out = state == WR ? data_buf : cpu_data_out;
    ext_rnw = dma_own ? state == RD : cpu_rnw;
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state <= IDLE;
      hold <= 1'b0;
      dma_busy <= 1'b0;
      dma_done <= 1'b0;
      cur_src <= '0;
      cur_dst <= '0;
      remaining <= '0;
      gap_cnt <= '0;
      data_buf <= '0;
    end else begin
      dma_done <= 1'b0;
      case (state)
        IDLE: if (dma_start) begin
          cur_src <= dma_src;
          cur_dst <= dma_dst;
          remaining <= dma_len == '0 ? {1'b1, {LEN_W{1'b0}}} : {1'b0, dma_len};
          hold <= 1'b1;
          dma_busy <= 1'b1;
          state <= REQ;
        end
        REQ: if (cpu_rnw && hold && mem_ready) state <= RD;
        RD: if (mem_ready) begin
          data_buf <= ext_data_in;
          cur_src <= cur_src + 16'd1;
          state <= WR;
        end
        WR: if (mem_ready) begin
          cur_dst <= cur_dst + 16'd1;
          remaining <= remaining - 1'b1;
          if (remaining == {{LEN_W{1'b0}}, 1'b1}) begin
            hold <= 1'b0;
            dma_busy <= 1'b0;
            dma_done <= 1'b1;
            state <= IDLE;
          end else if (GAP_CYCLES == 0) state <= RD;
          else begin
            hold <= 1'b0;
            gap_cnt <= GW'(GAP_CYCLES);
            state <= GAP;
          end
        end
        GAP: if (gap_cnt == GW'(1)) begin
          hold <= 1'b1;
          state <= REQ;
        end else gap_cnt <= gap_cnt - 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_dma_bus_arbiter.sv
// tb_dma_bus_arbiter: self-checking bench for dma_bus_arbiter with burst and cycle-stealing instances
module tb_dma_bus_arbiter;
  logic clk = 1'b0, nrst = 1'b0, mem_ready = 1'b1;
  logic [7:0] cahi = 8'h80, calo = 8'h00, cdout = 8'h00;
  logic crnw = 1'b1;
  logic [1:0] start = '0;
  logic [15:0] src = '0, dst = '0;
  logic [7:0] len = '0;
  logic [1:0][7:0] eahi, ealo, edout, edin;
  logic [1:0] ernw, crdy, busy, done;
  logic [7:0] mem [2][65536];
  logic [24:0] tq [$];
  int done_cnt [2];
  int checks = 0, errors = 0;
  typedef struct {
    logic [7:0] ahi, alo, dout;
    logic rnw, mrdy;
    logic [15:0] eaddr;
    logic [7:0] edata;
    logic ernw, rdy;
  } vec_t;
  vec_t vt [5];
  always #5 clk = ~clk;
  dma_bus_arbiter #(.LEN_W(8), .GAP_CYCLES(0)) u0 (
    .clk(clk), .nrst(nrst), .mem_ready(mem_ready),
    .cpu_addr_hi(cahi), .cpu_addr_lo(calo), .cpu_data_out(cdout), .cpu_rnw(crnw), .cpu_ready(crdy[0]),
    .ext_addr_hi(eahi[0]), .ext_addr_lo(ealo[0]), .ext_data_out(edout[0]), .ext_rnw(ernw[0]), .ext_data_in(edin[0]),
    .dma_start(start[0]), .dma_src(src), .dma_dst(dst), .dma_len(len), .dma_busy(busy[0]), .dma_done(done[0])
  );
  dma_bus_arbiter #(.LEN_W(8), .GAP_CYCLES(2)) u1 (
    .clk(clk), .nrst(nrst), .mem_ready(mem_ready),
    .cpu_addr_hi(cahi), .cpu_addr_lo(calo), .cpu_data_out(cdout), .cpu_rnw(crnw), .cpu_ready(crdy[1]),
    .ext_addr_hi(eahi[1]), .ext_addr_lo(ealo[1]), .ext_data_out(edout[1]), .ext_rnw(ernw[1]), .ext_data_in(edin[1]),
    .dma_start(start[1]), .dma_src(src), .dma_dst(dst), .dma_len(len), .dma_busy(busy[1]), .dma_done(done[1])
  );
  assign edin[0] = mem[0][{eahi[0], ealo[0]}];
  assign edin[1] = mem[1][{eahi[1], ealo[1]}];
  always @(negedge clk)
    if (nrst)
      for (int i = 0; i < 2; i++) begin
        if (done[i]) done_cnt[i]++;
        if (mem_ready) begin
          if (!ernw[i]) mem[i][{eahi[i], ealo[i]}] = edout[i];
          if (i == 0 && {eahi[0], ealo[0]} != 16'h8000)
            tq.push_back({ernw[0], eahi[0], ealo[0], ernw[0] ? edin[0] : edout[0]});
        end
      end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic core_read;
    cahi = 8'h80;
    calo = 8'h00;
    cdout = 8'h00;
    crnw = 1'b1;
  endtask
  task automatic cyc(input int i, input string nm, input logic [15:0] a, input logic rnw, input logic [7:0] d,
                     input logic rdy, input logic bsy, input logic dn);
    @(negedge clk);
    chk({nm, "_addr"}, {eahi[i], ealo[i]}, a);
    chk({nm, "_rnw"}, ernw[i], rnw);
    if (!rnw) chk({nm, "_data"}, edout[i], d);
    chk({nm, "_ready"}, crdy[i], rdy);
    chk({nm, "_busy"}, busy[i], bsy);
    chk({nm, "_done"}, done[i], dn);
    step;
  endtask
  task automatic run_copy(input logic [15:0] s, input logic [15:0] d, input logic [7:0] l, input bit rnd);
    logic [24:0] exp_q [$];
    logic [15:0] ra, wa;
    int n, d0;
    n = l == 8'd0 ? 256 : int'(l);
    for (int k = 0; k < n; k++) begin
      ra = s + 16'(k);
      wa = d + 16'(k);
      exp_q.push_back({1'b1, ra, mem[0][ra]});
      exp_q.push_back({1'b0, wa, mem[0][ra]});
    end
    core_read;
    tq.delete();
    d0 = done_cnt[0];
    src = s;
    dst = d;
    len = l;
    start[0] = 1'b1;
    step;
    start[0] = 1'b0;
    for (int c = 0; c < 2000 && done_cnt[0] == d0; c++) begin
      mem_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      step;
    end
    mem_ready = 1'b1;
    step;
    step;
    chk("copy_done_pulses", done_cnt[0] - d0, 1);
    chk("copy_busy_after", busy[0], 1'b0);
    chk("copy_ready_after", crdy[0], 1'b1);
    chk("copy_trace_len", tq.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < tq.size(); k++) chk("copy_bus_cycle", tq[k], exp_q[k]);
  endtask
  initial begin
    int d0;
    vt[0] = '{8'h12, 8'h34, 8'h56, 1'b1, 1'b1, 16'h1234, 8'h56, 1'b1, 1'b1};
    vt[1] = '{8'hFF, 8'hFE, 8'h01, 1'b0, 1'b1, 16'hFFFE, 8'h01, 1'b0, 1'b1};
    vt[2] = '{8'h00, 8'h00, 8'hA5, 1'b0, 1'b0, 16'h0000, 8'hA5, 1'b0, 1'b0};
    vt[3] = '{8'h80, 8'h00, 8'h00, 1'b1, 1'b0, 16'h8000, 8'h00, 1'b1, 1'b0};
    vt[4] = '{8'hC0, 8'hDE, 8'h7E, 1'b1, 1'b1, 16'hC0DE, 8'h7E, 1'b1, 1'b1};
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 65536; a++) mem[i][a] = 8'($urandom);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", crdy[i], 1'b1);
      chk("rst_busy", busy[i], 1'b0);
      chk("rst_done", done[i], 1'b0);
      chk("rst_addr", {eahi[i], ealo[i]}, 16'h8000);
      chk("rst_rnw", ernw[i], 1'b1);
    end
    step;
    nrst = 1'b1;
    for (int v = 0; v < 5; v++) begin
      cahi = vt[v].ahi;
      calo = vt[v].alo;
      cdout = vt[v].dout;
      crnw = vt[v].rnw;
      mem_ready = vt[v].mrdy;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk("idle_addr", {eahi[i], ealo[i]}, vt[v].eaddr);
        chk("idle_data", edout[i], vt[v].edata);
        chk("idle_rnw", ernw[i], vt[v].ernw);
        chk("idle_ready", crdy[i], vt[v].rdy);
      end
      step;
    end
    core_read;
    mem_ready = 1'b1;
    mem[0][16'h0200] = 8'hAA;
    mem[0][16'h0201] = 8'hBB;
    mem[0][16'h0202] = 8'hCC;
    d0 = done_cnt[0];
    src = 16'h0200;
    dst = 16'h0300;
    len = 8'd3;
    start[0] = 1'b1;
    step;
    start[0] = 1'b0;
    cyc(0, "burst_req", 16'h8000, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc(0, "burst_rd0", 16'h0200, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc(0, "burst_wr0", 16'h0300, 1'b0, 8'hAA, 1'b0, 1'b1, 1'b0);
    cyc(0, "burst_rd1", 16'h0201, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc(0, "burst_wr1", 16'h0301, 1'b0, 8'hBB, 1'b0, 1'b1, 1'b0);
    cyc(0, "burst_rd2", 16'h0202, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc(0, "burst_wr2", 16'h0302, 1'b0, 8'hCC, 1'b0, 1'b1, 1'b0);
    cyc(0, "burst_end", 16'h8000, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
    cyc(0, "burst_idle", 16'h8000, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("burst_mem0", mem[0][16'h0300], 8'hAA);
    chk("burst_mem1", mem[0][16'h0301], 8'hBB);
    chk("burst_mem2", mem[0][16'h0302], 8'hCC);
    chk("burst_done_pulses", done_cnt[0] - d0, 1);
    mem[0][16'h0400] = 8'h5A;
    src = 16'h0400;
    dst = 16'h0500;
    len = 8'd1;
    start[0] = 1'b1;
    step;
    start[0] = 1'b0;
    cahi = 8'h01; calo = 8'hFF; cdout = 8'h12; crnw = 1'b0;
    cyc(0, "brk_w0", 16'h01FF, 1'b0, 8'h12, 1'b0, 1'b1, 1'b0);
    calo = 8'hFE; cdout = 8'h34;
    cyc(0, "brk_w1", 16'h01FE, 1'b0, 8'h34, 1'b0, 1'b1, 1'b0);
    calo = 8'hFD; cdout = 8'h56;
    cyc(0, "brk_w2", 16'h01FD, 1'b0, 8'h56, 1'b0, 1'b1, 1'b0);
    core_read;
    cyc(0, "brk_rd_core", 16'h8000, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc(0, "brk_rd", 16'h0400, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc(0, "brk_wr", 16'h0500, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0);
    cyc(0, "brk_end", 16'h8000, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("brk_mem_1ff", mem[0][16'h01FF], 8'h12);
    chk("brk_mem_1fe", mem[0][16'h01FE], 8'h34);
    chk("brk_mem_1fd", mem[0][16'h01FD], 8'h56);
    chk("brk_mem_500", mem[0][16'h0500], 8'h5A);
    run_copy(16'hFFFF, 16'h00FF, 8'd2, 1'b0);
    run_copy(16'h4000, 16'h5000, 8'd0, 1'b0);
    for (int r = 0; r < 6; r++)
      run_copy(16'($urandom_range(0, 16'h0FFF)), 16'h2000 + 16'($urandom_range(0, 16'h0FFF)),
               8'($urandom_range(1, 40)), 1'b1);
    core_read;
    mem_ready = 1'b1;
    mem[1][16'h0600] = 8'h11;
    mem[1][16'h0601] = 8'h22;
    d0 = done_cnt[1];
    src = 16'h0600;
    dst = 16'h0700;
    len = 8'd2;
    start[1] = 1'b1;
    step;
    start[1] = 1'b0;
    cyc(1, "gap_req0", 16'h8000, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc(1, "gap_rd0", 16'h0600, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc(1, "gap_wr0", 16'h0700, 1'b0, 8'h11, 1'b0, 1'b1, 1'b0);
    cyc(1, "gap_free0", 16'h8000, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
    cyc(1, "gap_free1", 16'h8000, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
    cyc(1, "gap_req1", 16'h8000, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc(1, "gap_rd1", 16'h0601, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc(1, "gap_wr1", 16'h0701, 1'b0, 8'h22, 1'b0, 1'b1, 1'b0);
    cyc(1, "gap_end", 16'h8000, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("gap_done_pulses", done_cnt[1] - d0, 1);
    chk("gap_mem0", mem[1][16'h0700], 8'h11);
    chk("gap_mem1", mem[1][16'h0701], 8'h22);
    d0 = done_cnt[1];
    dst = 16'h0710;
    len = 8'd4;
    start[1] = 1'b1;
    step;
    start[1] = 1'b0;
    cyc(1, "abort_req", 16'h8000, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc(1, "abort_rd0", 16'h0600, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) cyc(1, "stall_wr", 16'h0710, 1'b0, 8'h11, 1'b0, 1'b1, 1'b0);
    mem_ready = 1'b1;
    cyc(1, "stall_wr_done", 16'h0710, 1'b0, 8'h11, 1'b0, 1'b1, 1'b0);
    cyc(1, "abort_gap0", 16'h8000, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
    cyc(1, "abort_gap1", 16'h8000, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
    cyc(1, "abort_req1", 16'h8000, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    mem_ready = 1'b0;
    cyc(1, "abort_rd1", 16'h0601, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    mem_ready = 1'b1;
    nrst = 1'b0;
    #2;
    chk("abort_busy", busy[1], 1'b0);
    chk("abort_done", done[1], 1'b0);
    chk("abort_ready", crdy[1], 1'b1);
    chk("abort_addr", {eahi[1], ealo[1]}, 16'h8000);
    chk("abort_rnw", ernw[1], 1'b1);
    nrst = 1'b1;
    repeat (4) step;
    chk("abort_no_done", done_cnt[1] - d0, 0);
    chk("abort_busy_after", busy[1], 1'b0);
    chk("abort_ready_after", crdy[1], 1'b1);
    chk("abort_mem_kept", mem[1][16'h0710], 8'h11);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dma_bus_arbiter.md
Name: dma_bus_arbiter

Overview:
- Shares the external 8-bit data / 16-bit address bus between the 8227 core and a memory-to-memory DMA engine.
- Sits between top8227 and the memory system.
- Stalls the core through its ready input. The core honours ready only on read cycles, so the arbiter must wait for one before taking the bus.
- Copies LEN bytes from src to dst as alternating read/write cycles. Supports burst mode, or cycle-stealing mode with gaps handed back to the core.

Parameters:
- LEN_W, 8, width of the transfer length; length 0 means 2^LEN_W bytes.
- GAP_CYCLES, 0, cycles the bus is returned to the core after each byte; 0 means burst.

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- mem_ready  in  1  external memory ready; low stalls the current bus cycle
- cpu_addr_hi / cpu_addr_lo  in  8 each  core AddressBusHigh/Low
- cpu_data_out  in  8  core dataBusOutput
- cpu_rnw  in  1  core readNotWrite
- cpu_ready  out  1  to core ready
- ext_addr_hi / ext_addr_lo  out  8 each  external address bus
- ext_data_out  out  8  external write data
- ext_rnw  out  1  external readNotWrite
- ext_data_in  in  8  external read data; also wired to core dataBusInput
- dma_start  in  1  single-cycle start pulse
- dma_src  in  16  source start address
- dma_dst  in  16  destination start address
- dma_len  in  LEN_W  byte count
- dma_busy  out  1  high from accepted start until return to IDLE
- dma_done  out  1  one-cycle pulse after the final write

Behaviour:
- Reset (async, nrst=0):
  - state=IDLE, dma_busy=0, dma_done=0, cpu_ready=mem_ready.
  - Address/count/data registers cleared.
  - External bus passes through the core signals.
  - Reset mid-transfer aborts immediately; no done pulse.
- hold: registered internal signal. cpu_ready = mem_ready & ~hold (combinational).
- Bus mux:
  - States IDLE, REQ and GAP: ext_* = cpu_* (pass-through).
  - States RD and WR: ext_* driven by the DMA.
- IDLE:
  - dma_start=1 latches src, dst, len into cur_src, cur_dst, remaining (len 0 is loaded as 2^LEN_W).
  - Sets hold=1 and dma_busy=1; next state REQ.
  - dma_start while busy is ignored; no queueing.
- REQ:
  - Core owns the bus. Write cycles (cpu_rnw=0) proceed because the core ignores ready on writes.
  - On a clock edge where cpu_rnw=1 and hold=1, the core is stalled; next state RD.
  - While mem_ready=0, remain in REQ.
- RD:
  - ext_addr = cur_src, ext_rnw=1.
  - On an edge with mem_ready=1: buf <= ext_data_in, cur_src += 1 (16-bit wrap from FFFF to 0000), next state WR.
  - mem_ready=0 holds the state and all registers.
- WR:
  - ext_addr = cur_dst, ext_rnw=0, ext_data_out = buf.
  - On an edge with mem_ready=1: cur_dst += 1 (wraps), remaining -= 1.
  - If remaining was 1: hold <= 0, dma_busy <= 0, dma_done <= 1 (one-cycle pulse), next state IDLE.
  - Else if GAP_CYCLES=0: next state RD.
  - Else: hold <= 0, gap counter <= GAP_CYCLES, next state GAP.
- GAP:
  - Core owns the bus, cpu_ready=mem_ready.
  - Counter decrements each cycle. When it reaches 1: hold <= 1, next state REQ.
- Latency:
  - Best case: start at edge N, REQ at N+1, first RD at N+2 if the core is reading.
  - Each byte costs 2 bus cycles, plus GAP_CYCLES, plus a REQ wait of at least 1 cycle when gaps are used.
- Core stall semantics:
  - The core retains its stalled read address.
  - After release, the core's stalled read completes normally; the arbiter never alters core-visible state.
- dma_done and dma_start in the same cycle: done is reported, and the start is accepted because the state is IDLE.

Test Plan:
- Reset → cpu_ready=1, dma_busy=0, ext_* track cpu_*.
- Burst copy: src=0x0200, dst=0x0300, len=3, memory 0x0200..0x0202 = AA,BB,CC, core reading.
  - Required: RD/WR alternate for 6 cycles, 0x0300..0x0302 = AA,BB,CC.
  - Required: dma_done pulses once, cpu_ready low throughout and restored after.
- Start while the core performs 3 consecutive writes (BRK push): the arbiter stays in REQ for 3 cycles, the writes reach memory unaltered, and RD begins after the first core read.
- Wrap: src=0xFFFF, dst=0x00FF, len=2 → reads at FFFF then 0000, writes at 00FF then 0100.
- len=0 with LEN_W=8 → exactly 256 write cycles, then dma_done.
- GAP_CYCLES=2, len=2 → the core regains ready for 2 cycles between bytes. Second part: mem_ready=0 for 3 cycles during WR, then nrst pulsed during RD → state holds during the stall, then returns to IDLE with no done pulse and ready high.
